// File: rtl/oddr_pkg.sv
// rtl/oddr_pkg.sv - shared constants for the behavioural DDR output register
package oddr_pkg;

    localparam logic RST_VAL_DEFAULT = 1'b0;

    // TMDS lane ordering used by the 4-lane DVI instance
    localparam int TMDS_LANES = 4;

    typedef enum logic [1:0] {
        TMDS_BLUE  = 2'd0,
        TMDS_GREEN = 2'd1,
        TMDS_RED   = 2'd2,
        TMDS_CLOCK = 2'd3
    } tmds_lane_e;

endpackage

// File: rtl/oddr_lane.sv
// rtl/oddr_lane.sv - single-bit DDR slice: rising-edge capture, falling-edge hold, phase mux
module oddr_lane
    import oddr_pkg::*;
#(
    parameter logic RST_VAL = RST_VAL_DEFAULT
) (
    input  logic sclk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic sdr,
    output logic q
);

    logic d0_r;
    logic d1_r;
    logic d1_f;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            d0_r <= RST_VAL;
            d1_r <= RST_VAL;
        end else begin
            d0_r <= d0;
            d1_r <= d1;
        end
    end

    // Re-timed on the falling edge so the low-phase source is settled before it is selected
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            d1_f <= RST_VAL;
        end else begin
            d1_f <= d1_r;
        end
    end

    assign q = (sclk || sdr) ? d0_r : d1_f;

endmodule

// File: rtl/oddr_x1f.sv
// rtl/oddr_x1f.sv - WIDTH-lane behavioural DDR output register; optional ODDR_SDR_MODE_EN adds sdr_mode
module oddr_x1f
    import oddr_pkg::*;
#(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = RST_VAL_DEFAULT
) (
    input  logic             SCLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
`ifdef ODDR_SDR_MODE_EN
    input  logic             sdr_mode,
`endif
    output logic [WIDTH-1:0] Q
);

    logic mode_r;

`ifdef ODDR_SDR_MODE_EN
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            mode_r <= 1'b0;
        end else begin
            mode_r <= sdr_mode;
        end
    end
`else
    assign mode_r = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        oddr_lane #(
            .RST_VAL (RST_VAL)
        ) u_lane (
            .sclk (SCLK),
            .rst  (RST),
            .d0   (D0[i]),
            .d1   (D1[i]),
            .sdr  (mode_r),
            .q    (Q[i])
        );
    end

endmodule

// File: tb/tb_oddr_x1f.sv
// tb/tb_oddr_x1f.sv - scoreboard bench for oddr_x1f (4 lanes); covers sdr_mode when ODDR_SDR_MODE_EN is set
module tb_oddr_x1f;

    localparam int W = 4;

    logic         SCLK;
    logic         RST;
    logic [W-1:0] D0;
    logic [W-1:0] D1;
    logic [W-1:0] Q;
`ifdef ODDR_SDR_MODE_EN
    logic         sdr_mode;
`endif

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_v;

    oddr_x1f #(
        .WIDTH   (W),
        .RST_VAL (1'b0)
    ) dut (
        .SCLK     (SCLK),
        .RST      (RST),
        .D0       (D0),
        .D1       (D1),
`ifdef ODDR_SDR_MODE_EN
        .sdr_mode (sdr_mode),
`endif
        .Q        (Q)
    );

    initial SCLK = 1'b0;
    always #5 SCLK = ~SCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "timeout");
    end

    // Drive a pair from the low phase, queue both phase expectations, settle into the high phase.
    // Inputs are then scrambled: changes after the rising edge must not reach Q.
    task automatic step_hi(input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
        D0 = d0;
        D1 = d1;
        exp_q.push_back(e_hi);
        exp_q.push_back(e_lo);
        @(posedge SCLK);
        #2;
        D0 = ~d0;
        D1 = ~d1;
    endtask

    task automatic step_lo();
        @(negedge SCLK);
        #2;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step_hi('1, '1, '0, '0);
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL reset_hi c=%0d got=%b exp=%b", c, Q, exp_v); end
            step_lo();
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL reset_lo c=%0d got=%b exp=%b", c, Q, exp_v); end
        end
        RST = 1'b0;
    endtask

    task automatic test_basic_ddr();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) step_hi('1, '0, '1, '0);
            else       step_hi('0, '1, '0, '1);
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL basic_hi c=%0d got=%b exp=%b", c, Q, exp_v); end
            step_lo();
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL basic_lo c=%0d got=%b exp=%b", c, Q, exp_v); end
        end
    endtask

    task automatic test_pattern();
        logic [1:0] pairs [4];
        logic       seq   [8];
        pairs = '{2'b10, 2'b01, 2'b11, 2'b00};
        seq   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int c = 0; c < 4; c++) begin
            step_hi({W{pairs[c][1]}}, {W{pairs[c][0]}}, {W{seq[2*c]}}, {W{seq[2*c+1]}});
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL pattern_hi c=%0d got=%b exp=%b", c, Q, exp_v); end
            step_lo();
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL pattern_lo c=%0d got=%b exp=%b", c, Q, exp_v); end
        end
    endtask

    task automatic test_async_reset();
        step_hi('1, '1, '1, '1);
        exp_v = exp_q.pop_front();
        tests++;
        if (Q !== exp_v) begin failed++; $display("FAIL async_pre got=%b exp=%b", Q, exp_v); end
        void'(exp_q.pop_front());
        #1;
        RST = 1'b1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front();
        tests++;
        if (Q !== exp_v) begin failed++; $display("FAIL async_mid_high got=%b exp=%b", Q, exp_v); end
        step_lo();
        exp_v = exp_q.pop_front();
        tests++;
        if (Q !== exp_v) begin failed++; $display("FAIL async_low got=%b exp=%b", Q, exp_v); end
        RST = 1'b0;
        step_hi(4'b0101, 4'b0011, 4'b0101, 4'b0011);
        exp_v = exp_q.pop_front();
        tests++;
        if (Q !== exp_v) begin failed++; $display("FAIL async_release_hi got=%b exp=%b", Q, exp_v); end
        step_lo();
        exp_v = exp_q.pop_front();
        tests++;
        if (Q !== exp_v) begin failed++; $display("FAIL async_release_lo got=%b exp=%b", Q, exp_v); end
    endtask

    task automatic test_multi_lane();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) step_hi(4'b0110, 4'b1010, 4'b0110, 4'b1010);
            else        step_hi(4'b1010, 4'b0110, 4'b1010, 4'b0110);
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL lanes_hi c=%0d got=%b exp=%b", c, Q, exp_v); end
            step_lo();
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL lanes_lo c=%0d got=%b exp=%b", c, Q, exp_v); end
        end
    endtask

`ifdef ODDR_SDR_MODE_EN
    task automatic test_sdr_mode();
        for (int c = 0; c < 4; c++) begin
            sdr_mode = (c < 2);
            if (c < 2) step_hi('1, '0, '1, '1);
            else       step_hi('1, '0, '1, '0);
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL sdr_hi c=%0d got=%b exp=%b", c, Q, exp_v); end
            step_lo();
            exp_v = exp_q.pop_front();
            tests++;
            if (Q !== exp_v) begin failed++; $display("FAIL sdr_lo c=%0d got=%b exp=%b", c, Q, exp_v); end
        end
    endtask
`endif

    initial begin
        RST = 1'b1;
        D0  = '0;
        D1  = '0;
`ifdef ODDR_SDR_MODE_EN
        sdr_mode = 1'b0;
`endif
        #2;
        tests++;
        if (Q !== '0) begin failed++; $display("FAIL reset_initial got=%b exp=%b", Q, 4'b0000); end
        test_reset();
        test_basic_ddr();
        test_pattern();
        test_async_reset();
        test_multi_lane();
`ifdef ODDR_SDR_MODE_EN
        test_sdr_mode();
`endif
        tests++;
        if (exp_q.size() != 0) begin failed++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
